// File: rtl/operand_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// operand_sweep_ctrl_if
//   Bundles the control handshake and the operand/result bus between the sweep
//   sequencer and its environment (comparator datapath plus test host).
//
//   master : the sequencer itself (drives operands and status)
//   slave  : the environment (drives start/abort/seed and the comparator result)
//
//   Signals
//     start    begin a sweep (sampled only while idle)
//     abort    end a running sweep early
//     seed     base operand, latched on start
//     res_in   1-bit comparator result
//     A..D     operand vector presented to the datapath
//     busy     high while the sweep is running
//     done     one-cycle pulse at the end of a sweep
//     vec_idx  index of the vector currently driven
//     hit_cnt  number of sampled vectors whose result was 1
// -----------------------------------------------------------------------------
interface operand_sweep_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] seed;
   logic             res_in;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] C;
   logic [WIDTH-1:0] D;
   logic             busy;
   logic             done;
   logic [15:0]      vec_idx;
   logic [15:0]      hit_cnt;

   modport master (
      input  start, abort, seed, res_in,
      output A, B, C, D, busy, done, vec_idx, hit_cnt
   );

   modport slave (
      output start, abort, seed, res_in,
      input  A, B, C, D, busy, done, vec_idx, hit_cnt
   );
endinterface

// File: rtl/operand_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// operand_sweep_ctrl
//   Stimulus sequencer for the 4-operand comparator datapath. On start it walks
//   NVEC operand vectors over A..D, holds each vector for LAT cycles, samples
//   the comparator result on the last cycle of each vector and counts hits.
//
//   Parameters
//     WIDTH  operand width, must be even (D is the half-swap of A)
//     LAT    comparator latency / vector period in cycles, 1..15
//     NVEC   vectors per sweep, 1..65535
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    operand_sweep_ctrl_if.master (start/abort/seed/res_in in;
//            A..D, busy, done, vec_idx, hit_cnt out)
//
//   Build option
//     SWEEP_LFSR_EN  when defined, A comes from an 8-bit Fibonacci LFSR
//                    (x^8+x^6+x^5+x^4+1) seeded on start instead of the linear
//                    base+index map. Requires WIDTH == 8.
// -----------------------------------------------------------------------------
module operand_sweep_ctrl #(
   parameter int WIDTH = 8,
   parameter int LAT   = 1,
   parameter int NVEC  = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   operand_sweep_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0]       LAT_CNT  = 4'(LAT);
   localparam logic [15:0]      LAST_IDX = 16'(NVEC - 1);
   localparam logic [WIDTH-1:0] C_OFS    = WIDTH'('h55);

   state_t           state_q, state_d;
   logic [3:0]       lat_q,   lat_d;
   logic [15:0]      idx_q,   idx_d;
   logic [15:0]      hit_q,   hit_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     c_q,   d_q;

   // Last cycle of the current vector: the result is sampled on this edge.
   logic sample_edge;
   assign sample_edge = (lat_q == 4'd1);

   // Operand value after a vector advance, and the value loaded on start.
   logic [WIDTH-1:0] a_step, a_load;
`ifdef SWEEP_LFSR_EN
   assign a_step = {a_q[6:0], a_q[7] ^ a_q[5] ^ a_q[4] ^ a_q[3]};
   // The all-zero state is a lock-up state for this LFSR.
   assign a_load = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
`else
   // base+idx+1 == A+1 (mod 2^WIDTH), so no separate base register is kept.
   assign a_step = a_q + WIDTH'(1);
   assign a_load = bus.seed;
`endif

   // ---------------------------------------------------------------- state reg
   // NOTE: state is written with non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent behaviour.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // --------------------------------------------------------------- next state
   // NOTE: every variable driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         // abort wins over the final sample of the sweep.
         S_RUN:   if (bus.abort || (sample_edge && idx_q == LAST_IDX))
                     state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------ outputs (FSM)
   always_comb begin
      bus.busy = (state_q == S_RUN);
      bus.done = (state_q == S_DONE);
   end

   // -------------------------------------------------------- datapath next
   always_comb begin
      lat_d = lat_q;
      idx_d = idx_q;
      hit_d = hit_q;
      a_d   = a_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d   = a_load;
               idx_d = '0;
               hit_d = '0;
               lat_d = LAT_CNT;
            end
         end
         S_RUN: begin
            // An aborted vector is neither sampled nor advanced.
            if (!bus.abort) begin
               lat_d = lat_q - 4'd1;
               if (sample_edge) begin
                  hit_d = hit_q + {15'd0, bus.res_in};
                  if (idx_q != LAST_IDX) begin
                     idx_d = idx_q + 16'd1;
                     a_d   = a_step;
                     lat_d = LAT_CNT;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // --------------------------------------------------------- datapath regs
   // B..D are registered alongside A so all four operands change on one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_q <= '0;
         idx_q <= '0;
         hit_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         d_q   <= '0;
      end else begin
         lat_q <= lat_d;
         idx_q <= idx_d;
         hit_q <= hit_d;
         a_q   <= a_d;
         b_q   <= ~a_d;
         c_q   <= a_d + C_OFS;
         d_q   <= {a_d[WIDTH/2-1:0], a_d[WIDTH-1:WIDTH/2]};
      end
   end

   assign bus.A       = a_q;
   assign bus.B       = b_q;
   assign bus.C       = c_q;
   assign bus.D       = d_q;
   assign bus.vec_idx = idx_q;
   assign bus.hit_cnt = hit_q;

endmodule
